// File: rtl/key_expansion.sv
// Iterative AES key schedule: one 32-bit schedule word per clock for 128/192/256-bit keys.
// The full schedule is presented as a flat vector, round key 0 first, valid while done is high.
module key_expansion #(
  parameter int Nk = 4,
  parameter int Nr = Nk + 6,
  parameter int W  = 4 * (Nr + 1)
) (
  input  logic                     clks,
  input  logic                     reset,
  input  logic                     start,
  input  logic [0:Nk*32-1]         key,
  output logic [0:128*(Nr+1)-1]    keys,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPAND = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // AES forward S-box, entry b at bits [8*b +: 8].
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_w [W];
  logic [5:0]  r_idx;
  logic [2:0]  r_phase;  // r_idx mod Nk, tracked incrementally to avoid a divider
  logic [7:0]  r_rcon;

  logic        w_accept;
  logic        w_last;
  logic [31:0] w_prev;
  logic [31:0] w_back;
  logic [31:0] w_temp;
  logic [31:0] w_new;

  assign w_accept = start && (r_state != S_EXPAND);
  assign w_last   = (r_idx == 6'(W - 1));

  always_ff @(posedge clks or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_next_state = S_EXPAND;
      S_EXPAND:       if (w_last) w_next_state = S_DONE;
      default:        w_next_state = S_IDLE;
    endcase
  end

  assign w_prev = r_w[r_idx - 6'd1];
  assign w_back = r_w[r_idx - 6'(Nk)];

  always_comb begin
    w_temp = w_prev;
    if (r_phase == 3'd0)
      w_temp = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {r_rcon, 24'h0};
    else if (Nk == 8 && r_phase == 3'd4)
      w_temp = sub_word(w_prev);
    w_new = w_back ^ w_temp;
  end

  // NOTE: the schedule storage is reset because it is an output and must read zero in reset.
  always_ff @(posedge clks or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < W; j++) r_w[j] <= '0;
      r_idx   <= '0;
      r_phase <= '0;
      r_rcon  <= 8'h01;
    end else if (w_accept) begin
      for (int j = 0; j < Nk; j++) r_w[j] <= key[32*j +: 32];
      for (int j = Nk; j < W; j++) r_w[j] <= '0;
      r_idx   <= 6'(Nk);
      r_phase <= '0;
      r_rcon  <= 8'h01;
    end else if (r_state == S_EXPAND) begin
      r_w[r_idx] <= w_new;
      r_idx      <= r_idx + 6'd1;
      r_phase    <= (r_phase == 3'(Nk - 1)) ? 3'd0 : r_phase + 3'd1;
      if (r_phase == 3'd0)
        r_rcon <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
    end
  end

  for (genvar j = 0; j < W; j++) begin : g_flat
    assign keys[32*j +: 32] = r_w[j];
  end

  assign busy = (r_state == S_EXPAND);
  assign done = (r_state == S_DONE);

endmodule
